// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and the companion receiver.
// Contents:
//   PAR_NONE / PAR_EVEN / PAR_ODD : parity mode encodings.
//   state_t                       : character framing states.
//   frame_bits()                  : line bit periods per character.
//   char_parity()                 : parity bit for one character.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        PAR,
        STOP
    } state_t;

    // Bit periods per character: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity,
                                      input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

    // Parity over the low data_bits of a character. Even parity makes the
    // total number of ones even; odd parity is its inverse.
    function automatic logic char_parity(input logic [7:0] data,
                                         input int data_bits, input int parity);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < data_bits) begin
                x = x ^ data[i];
            end
        end
        return (parity == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Handshake bundle between the frame scheduler and the UART transmitter.
// Signals:
//   start      : single-cycle transfer request (scheduler -> tx)
//   bus_in     : WIDTH-bit payload, character 0 in the low bits (scheduler -> tx)
//   busy       : transfer in progress (tx -> scheduler)
//   done       : one-cycle end-of-transfer pulse (tx -> scheduler)
//   serial_out : UART line, idle high (tx -> pin)
// Modports: master = scheduler side, slave = transmitter side.
interface uart_frame_tx_if #(
    parameter int WIDTH = 48
);
    logic             start;
    logic [WIDTH-1:0] bus_in;
    logic             busy;
    logic             done;
    logic             serial_out;

    modport master (
        output start,
        output bus_in,
        input  busy,
        input  done,
        input  serial_out
    );

    modport slave (
        input  start,
        input  bus_in,
        output busy,
        output done,
        output serial_out
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   clear  : hold the counter at zero (next bit period starts after release)
//   tick   : one-cycle pulse in the last cycle of each CYCLES_PER_BIT period
module uart_baud_tick #(
    parameter int CYCLES_PER_BIT = 391
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;

    logic [CW-1:0] cnt_reg;

    assign tick = !clear && (cnt_reg == CW'(CYCLES_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/uart_frame_tx.sv
// Multi-character UART transmitter. A start request captures NUM_BYTES
// characters of DATA_BITS each and sends them back to back, LSB first, each
// framed as start bit, data, optional parity, STOP_BITS stop bits.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (line forced idle high)
//   tx    : slave side of uart_frame_tx_if (start, bus_in, busy, done, serial_out)
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int NUM_BYTES      = 6,
    parameter int DATA_BITS      = 8,
    parameter int CYCLES_PER_BIT = 391,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_frame_tx_if.slave  tx
);
    localparam int W      = NUM_BYTES * DATA_BITS;
    localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int BIT_W  = 3;

    // Reject unsupported configurations at elaboration.
    generate
        if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bad_num_bytes
            $fatal(1, "uart_frame_tx: NUM_BYTES must be 1..16");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $fatal(1, "uart_frame_tx: DATA_BITS must be 5..8");
        end
        if (CYCLES_PER_BIT < 2) begin : g_bad_cycles
            $fatal(1, "uart_frame_tx: CYCLES_PER_BIT must be >= 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $fatal(1, "uart_frame_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $fatal(1, "uart_frame_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    state_t              state_reg, state_next;
    logic [W-1:0]        shift_reg, shift_next;
    logic                parity_reg, parity_next;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [BYTE_W-1:0]   byte_cnt_reg, byte_cnt_next;
    logic                serial_reg, serial_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                tick;
    logic                baud_clear;

    // The bit timer runs only while a transfer is active; holding it clear in
    // IDLE makes the first start bit last exactly one full period.
    assign baud_clear = (state_reg == IDLE);

    uart_baud_tick #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(baud_clear),
        .tick (tick)
    );

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        done_next     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (tx.start) begin
                    shift_next    = tx.bus_in;
                    parity_next   = char_parity(8'(tx.bus_in[DATA_BITS-1:0]),
                                                DATA_BITS, PARITY);
                    bit_cnt_next  = '0;
                    byte_cnt_next = '0;
                    state_next    = START_BIT;
                end
            end
            START_BIT: begin
                if (tick) begin
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    // Shifting every data bit leaves the next character
                    // sitting in the low bits when this one is finished.
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY != PAR_NONE) ? PAR : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    bit_cnt_next = '0;
                    state_next   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_reg == BIT_W'(STOP_BITS - 1)) begin
                        bit_cnt_next = '0;
                        if (byte_cnt_reg == BYTE_W'(NUM_BYTES - 1)) begin
                            byte_cnt_next = '0;
                            done_next     = 1'b1;
                            state_next    = IDLE;
                        end else begin
                            byte_cnt_next = byte_cnt_reg + 1'b1;
                            parity_next   = char_parity(8'(shift_reg[DATA_BITS-1:0]),
                                                        DATA_BITS, PARITY);
                            state_next    = START_BIT;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Line level follows the state being entered so serial_out is a
        // plain register with no combinational path to the pin.
        unique case (state_next)
            START_BIT: serial_next = 1'b0;
            DATA:      serial_next = shift_next[0];
            PAR:       serial_next = parity_next;
            default:   serial_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            serial_reg   <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            serial_reg   <= serial_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign tx.serial_out = serial_reg;
    assign tx.busy       = busy_reg;
    assign tx.done       = done_reg;

endmodule

// File: tb/tb_uart_frame_tx.sv
module tb_uart_frame_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start_v;
    logic [3:0]  ser_v;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [127:0] bus_v [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // a: 6 x 8N1   b: 1 x 7E1   c: 1 x 7O1   d: 2 x 8N2
    uart_frame_tx_if #(.WIDTH(48)) if_a ();
    uart_frame_tx_if #(.WIDTH(7))  if_b ();
    uart_frame_tx_if #(.WIDTH(7))  if_c ();
    uart_frame_tx_if #(.WIDTH(16)) if_d ();

    assign if_a.start  = start_v[0];
    assign if_a.bus_in = bus_v[0][47:0];
    assign if_b.start  = start_v[1];
    assign if_b.bus_in = bus_v[1][6:0];
    assign if_c.start  = start_v[2];
    assign if_c.bus_in = bus_v[2][6:0];
    assign if_d.start  = start_v[3];
    assign if_d.bus_in = bus_v[3][15:0];

    assign ser_v  = {if_d.serial_out, if_c.serial_out, if_b.serial_out, if_a.serial_out};
    assign busy_v = {if_d.busy, if_c.busy, if_b.busy, if_a.busy};
    assign done_v = {if_d.done, if_c.done, if_b.done, if_a.done};

    uart_frame_tx #(.NUM_BYTES(6), .DATA_BITS(8), .CYCLES_PER_BIT(CPB),
                    .PARITY(0), .STOP_BITS(1))
        dut_a (.clk(clk), .rst_n(rst_n), .tx(if_a));
    uart_frame_tx #(.NUM_BYTES(1), .DATA_BITS(7), .CYCLES_PER_BIT(CPB),
                    .PARITY(1), .STOP_BITS(1))
        dut_b (.clk(clk), .rst_n(rst_n), .tx(if_b));
    uart_frame_tx #(.NUM_BYTES(1), .DATA_BITS(7), .CYCLES_PER_BIT(CPB),
                    .PARITY(2), .STOP_BITS(1))
        dut_c (.clk(clk), .rst_n(rst_n), .tx(if_c));
    uart_frame_tx #(.NUM_BYTES(2), .DATA_BITS(8), .CYCLES_PER_BIT(CPB),
                    .PARITY(0), .STOP_BITS(2))
        dut_d (.clk(clk), .rst_n(rst_n), .tx(if_d));

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected line level for bit bi of character c.
    function automatic logic exp_bit(input logic [127:0] payload, input int c,
                                     input int bi, input int db, input int par);
        logic x;
        if (bi == 0) return 1'b0;
        if (bi <= db) return payload[c*db + bi - 1];
        if (par != 0 && bi == db + 1) begin
            x = 1'b0;
            for (int i = 0; i < db; i++) x = x ^ payload[c*db + i];
            return (par == 2) ? ~x : x;
        end
        return 1'b1;
    endfunction

    // Entered at the negedge of the first start-bit cycle; returns at the
    // negedge of the done cycle. Optionally pulses start with a different
    // payload at cycle inject_at.
    task automatic xfer(input int d, input int nb, input int db, input int par,
                        input int stops, input logic [127:0] payload,
                        input int inject_at, input logic [127:0] alt,
                        input string tag, output logic [15:0] line0);
        int fb, cyc, c, bi, k;
        fb  = 1 + db + ((par != 0) ? 1 : 0) + stops;
        cyc = nb * fb * CPB;
        line0 = '0;
        for (int t = 0; t < cyc; t++) begin
            c  = t / (fb * CPB);
            bi = (t / CPB) % fb;
            k  = t % CPB;
            if (k == 0 || k == CPB - 1)
                check($sformatf("%s_c%0d_b%0d_k%0d", tag, c, bi, k),
                      64'(ser_v[d]), 64'(exp_bit(payload, c, bi, db, par)));
            if (k == 0)
                check($sformatf("%s_busydone_c%0d_b%0d", tag, c, bi),
                      64'({busy_v[d], done_v[d]}), 64'(2'b10));
            if (c == 0 && k == CPB / 2) line0[bi] = ser_v[d];
            if (t == inject_at) begin
                start_v[d] = 1'b1;
                bus_v[d]   = alt;
            end else begin
                start_v[d] = 1'b0;
            end
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        check($sformatf("%s_done_cycle", tag),
              64'({busy_v[d], done_v[d], ser_v[d]}), 64'(3'b011));
        $display("xfer %s dut=%0d payload=%0h cycles=%0d", tag, d, payload, cyc);
    endtask

    // Start on dut d and land on the first start-bit cycle.
    task automatic kick(input int d, input logic [127:0] payload);
        bus_v[d]   = payload;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    // Parity check on a single-character 7-bit DUT: sample bit 8 mid-period
    // and time the done pulse from the first start-bit cycle.
    task automatic par_test(input int d, input logic exp_par, input string tag);
        int cyc;
        kick(d, 128'h55);
        check({tag, "_startbit"}, 64'({busy_v[d], ser_v[d]}), 64'(2'b10));
        repeat (8 * CPB + 1) @(negedge clk);
        check({tag, "_parbit"}, 64'(ser_v[d]), 64'(exp_par));
        cyc = 8 * CPB + 1;
        while (!done_v[d] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_at"}, 64'(cyc), 64'(10 * CPB));
        $display("parity %s dut=%0d done_at=%0d", tag, d, cyc);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] line0;
        int dcount;
        rst_n   = 1'b0;
        start_v = '0;
        for (int i = 0; i < 4; i++) bus_v[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_serial", 64'(ser_v[0]), 64'(1));
        check("rst_busy",   64'(busy_v[0]), 64'(0));
        check("rst_done",   64'(done_v[0]), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_line", 64'(ser_v), 64'(4'hF));

        // 0xA5 in char 0, zeros elsewhere; done exactly 240 cycles later.
        kick(0, 128'h0000_0000_00A5);
        xfer(0, 6, 8, 0, 1, 128'h0000_0000_00A5, -1, '0, "a5", line0);
        check("a5_line0", 64'(line0[9:0]), 64'(10'b1101001010));
        @(negedge clk);
        check("a5_done_single", 64'({busy_v[0], done_v[0]}), 64'(2'b00));

        // start mid-transfer with another payload must be ignored.
        kick(0, 128'h1234_5678_9ABC);
        xfer(0, 6, 8, 0, 1, 128'h1234_5678_9ABC, 50, 128'hFFFF_FFFF_FFFF,
             "ignore", line0);

        // start in the done cycle: next start bit immediately, busy low once.
        kick(0, 128'h00C3_0F5A_A5FF);
        check("b2b_accept", 64'({busy_v[0], ser_v[0]}), 64'(2'b10));
        xfer(0, 6, 8, 0, 1, 128'h00C3_0F5A_A5FF, -1, '0, "b2b", line0);
        @(negedge clk);
        check("b2b_done_single", 64'({busy_v[0], done_v[0]}), 64'(2'b00));

        // Reset during DATA of char 3 (a zero character, line low).
        kick(0, 128'h00FF_00FF_00FF);
        repeat (130) @(negedge clk);
        check("pre_rst_line", 64'({busy_v[0], ser_v[0]}), 64'(2'b10));
        rst_n = 1'b0;
        #1;
        check("async_rst_line", 64'({busy_v[0], ser_v[0]}), 64'(2'b01));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_v[0] || !ser_v[0]) dcount++;
        end
        check("rst_no_done", 64'(dcount), 64'(0));
        kick(0, 128'h0102_0304_0506);
        xfer(0, 6, 8, 0, 1, 128'h0102_0304_0506, -1, '0, "post_rst", line0);

        // 7-bit parity: 0x55 has four ones.
        par_test(1, 1'b0, "even");
        par_test(2, 1'b1, "odd");

        // Two stop bits, two characters, no extra gap.
        kick(3, 128'h3CA5);
        xfer(3, 2, 8, 0, 2, 128'h3CA5, -1, '0, "stop2", line0);
        check("stop2_line0", 64'(line0[10:0]), 64'(11'b11101001010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
